// File: rtl/bin2gray_ptr.sv
// -----------------------------------------------------------------------------
// bin2gray_ptr
//   Registered binary pointer with a registered Gray-coded copy. This is the
//   encoder half of an async-FIFO pointer pair. oGrayValue is driven directly
//   by a flop, so it can be fed into a synchroniser in another clock domain.
//
// Ports
//   iClk        clock, rising-edge
//   iRst        synchronous reset, active-high
//   iInc        advance the pointer by one (modulo 2^DATA_WIDTH)
//   iLoad       load iLoadValue (takes priority over iInc)
//   iLoadValue  binary value to load
//   oBinValue   registered binary pointer
//   oGrayValue  registered Gray code of oBinValue
//   oBinNext    combinational value oBinValue takes at the next edge
//   oGrayNext   combinational Gray code of oBinNext
//   oWrap       registered one-cycle pulse after an all-ones -> zero increment
// -----------------------------------------------------------------------------
module bin2gray_ptr #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iInc,
    input  logic                  iLoad,
    input  logic [DATA_WIDTH-1:0] iLoadValue,
    output logic [DATA_WIDTH-1:0] oBinValue,
    output logic [DATA_WIDTH-1:0] oGrayValue,
    output logic [DATA_WIDTH-1:0] oBinNext,
    output logic [DATA_WIDTH-1:0] oGrayNext,
    output logic                  oWrap
);

    logic wrapNext;

    // Next-value selection. The reset leg is a don't-care for the register
    // (it is forced to zero below) but driving zero keeps the compare logic
    // downstream quiet during reset. iLoadValue is only selected when iLoad
    // is high, so an undriven load bus cannot leak into the pointer.
    always_comb begin
        oBinNext = oBinValue;
        if (iRst) begin
            oBinNext = '0;
        end else if (iLoad) begin
            oBinNext = iLoadValue;
        end else if (iInc) begin
            oBinNext = oBinValue + DATA_WIDTH'(1);
        end
    end

    // Logical shift leaves the MSB untouched after the XOR.
    assign oGrayNext = oBinNext ^ (oBinNext >> 1);

    // A wrap is only an increment out of all-ones; loads never count.
    assign wrapNext = !iRst && !iLoad && iInc && (&oBinValue);

    // Binary and Gray registers share one enable-free update so they can
    // never be a cycle apart.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oBinValue  <= '0;
            oGrayValue <= '0;
            oWrap      <= 1'b0;
        end else begin
            oBinValue  <= oBinNext;
            oGrayValue <= oGrayNext;
            oWrap      <= wrapNext;
        end
    end

endmodule

// File: tb/tb_bin2gray_ptr.sv
// -----------------------------------------------------------------------------
// tb_bin2gray_ptr
//   Drives three pointer instances (2, 4 and 8 bits) from one set of control
//   inputs. Expected values come from a hand-written vector table (4-bit),
//   a reflected-Gray lookup table and a modulo-counter reference model.
// -----------------------------------------------------------------------------
module tb_bin2gray_ptr;

    logic       iClk = 1'b0;
    logic       iRst = 1'b0;
    logic       iInc = 1'b0;
    logic       iLoad = 1'b0;
    logic [7:0] lvAll = 8'h00;

    logic [1:0] bin2, gray2, binN2, grayN2;
    logic [3:0] bin4, gray4, binN4, grayN4;
    logic [7:0] bin8, gray8, binN8, grayN8;
    logic       wrap2, wrap4, wrap8;

    int nChecks = 0;
    int nErrors = 0;

    always #5 iClk = ~iClk;

    bin2gray_ptr #(.DATA_WIDTH(2)) dut2 (
        .iClk(iClk), .iRst(iRst), .iInc(iInc), .iLoad(iLoad),
        .iLoadValue(lvAll[1:0]),
        .oBinValue(bin2), .oGrayValue(gray2), .oBinNext(binN2),
        .oGrayNext(grayN2), .oWrap(wrap2)
    );

    bin2gray_ptr #(.DATA_WIDTH(4)) dut4 (
        .iClk(iClk), .iRst(iRst), .iInc(iInc), .iLoad(iLoad),
        .iLoadValue(lvAll[3:0]),
        .oBinValue(bin4), .oGrayValue(gray4), .oBinNext(binN4),
        .oGrayNext(grayN4), .oWrap(wrap4)
    );

    bin2gray_ptr #(.DATA_WIDTH(8)) dut8 (
        .iClk(iClk), .iRst(iRst), .iInc(iInc), .iLoad(iLoad),
        .iLoadValue(lvAll),
        .oBinValue(bin8), .oGrayValue(gray8), .oBinNext(binN8),
        .oGrayNext(grayN8), .oWrap(wrap8)
    );

    // ---------------------------------------------------------------- model
    // Reflected binary Gray code built by mirroring; the first 2^W entries
    // form the W-bit code for every W <= 8.
    int grayTab[256];
    int mBin[3];
    int wrapCount[3];
    int widthOf[3] = '{2, 4, 8};

    function automatic int modOf(input int k);
        return 1 << widthOf[k];
    endfunction

    function automatic int aBin(input int k);
        case (k)
            0: return int'(bin2);
            1: return int'(bin4);
            default: return int'(bin8);
        endcase
    endfunction

    function automatic int aGray(input int k);
        case (k)
            0: return int'(gray2);
            1: return int'(gray4);
            default: return int'(gray8);
        endcase
    endfunction

    function automatic int aBinN(input int k);
        case (k)
            0: return int'(binN2);
            1: return int'(binN4);
            default: return int'(binN8);
        endcase
    endfunction

    function automatic int aGrayN(input int k);
        case (k)
            0: return int'(grayN2);
            1: return int'(grayN4);
            default: return int'(grayN8);
        endcase
    endfunction

    function automatic int aWrap(input int k);
        case (k)
            0: return int'(wrap2);
            1: return int'(wrap4);
            default: return int'(wrap8);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: apply controls, check the combinational next values, then
    // check every instance's registered outputs against the model.
    task automatic cycle(input bit r, input bit l, input bit i, input logic [7:0] v);
        int nb[3];
        int nw[3];
        int prevGray[3];
        iRst = r; iLoad = l; iInc = i; lvAll = v;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                nb[k] = 0; nw[k] = 0;
            end else if (l) begin
                nb[k] = int'(v) % modOf(k); nw[k] = 0;
            end else if (i) begin
                nb[k] = (mBin[k] + 1) % modOf(k);
                nw[k] = (mBin[k] == modOf(k) - 1) ? 1 : 0;
            end else begin
                nb[k] = mBin[k]; nw[k] = 0;
            end
            if (!r) begin
                chk($sformatf("binNext w%0d", widthOf[k]), aBinN(k), nb[k]);
                chk($sformatf("grayNext w%0d", widthOf[k]), aGrayN(k), grayTab[nb[k]]);
            end
            prevGray[k] = aGray(k);
        end
        @(posedge iClk);
        #1;
        for (int k = 0; k < 3; k++) begin
            mBin[k] = nb[k];
            chk($sformatf("bin w%0d", widthOf[k]), aBin(k), nb[k]);
            chk($sformatf("gray w%0d", widthOf[k]), aGray(k), grayTab[nb[k]]);
            chk($sformatf("wrap w%0d", widthOf[k]), aWrap(k), nw[k]);
            if (!r && !l)
                chk($sformatf("gray step bits w%0d", widthOf[k]),
                    $countones(prevGray[k] ^ aGray(k)), i ? 1 : 0);
            wrapCount[k] += aWrap(k);
        end
    endtask

    // ---------------------------------------------------------- vector table
    typedef struct {
        bit         r;
        bit         l;
        bit         i;
        logic [7:0] lv;
        int         expBin;
        int         expGray;
        int         expWrap;
    } vec_t;

    vec_t tbl[20];
    int   nVec;

    initial begin
        grayTab[0] = 0;
        for (int b = 0; b < 8; b++)
            for (int j = 0; j < (1 << b); j++)
                grayTab[(1 << b) + j] = grayTab[(1 << b) - 1 - j] | (1 << b);
        for (int k = 0; k < 3; k++) begin
            mBin[k] = 0; wrapCount[k] = 0;
        end

        // 4-bit expectations worked out by hand.
        tbl[0]  = '{1, 0, 0, 8'h0, 0,  4'b0000, 0};  // reset
        tbl[1]  = '{1, 0, 0, 8'h0, 0,  4'b0000, 0};
        tbl[2]  = '{0, 0, 0, 8'h0, 0,  4'b0000, 0};  // hold x5
        tbl[3]  = '{0, 0, 0, 8'h0, 0,  4'b0000, 0};
        tbl[4]  = '{0, 0, 0, 8'h0, 0,  4'b0000, 0};
        tbl[5]  = '{0, 0, 0, 8'h0, 0,  4'b0000, 0};
        tbl[6]  = '{0, 0, 0, 8'h0, 0,  4'b0000, 0};
        tbl[7]  = '{0, 0, 1, 8'h0, 1,  4'b0001, 0};
        tbl[8]  = '{0, 0, 1, 8'h0, 2,  4'b0011, 0};
        tbl[9]  = '{0, 0, 1, 8'h0, 3,  4'b0010, 0};
        tbl[10] = '{0, 1, 1, 8'h9, 9,  4'b1101, 0};  // load beats inc
        tbl[11] = '{0, 0, 1, 8'h0, 10, 4'b1111, 0};
        tbl[12] = '{0, 1, 0, 8'hF, 15, 4'b1000, 0};
        tbl[13] = '{0, 0, 1, 8'h0, 0,  4'b0000, 1};  // wrap pulse
        tbl[14] = '{0, 0, 0, 8'h0, 0,  4'b0000, 0};  // pulse is one cycle
        tbl[15] = '{0, 1, 0, 8'hF, 15, 4'b1000, 0};
        tbl[16] = '{1, 1, 1, 8'hF, 0,  4'b0000, 0};  // reset kills wrap
        tbl[17] = '{0, 1, 0, 8'hF, 15, 4'b1000, 0};
        tbl[18] = '{0, 1, 0, 8'h0, 0,  4'b0000, 0};  // load 0: no wrap
        tbl[19] = '{0, 1, 0, 8'h7, 7,  4'b0100, 0};
        nVec = 20;

        @(negedge iClk);
        for (int n = 0; n < nVec; n++) begin
            cycle(tbl[n].r, tbl[n].l, tbl[n].i, tbl[n].lv);
            chk($sformatf("vec%0d bin", n), int'(bin4), tbl[n].expBin);
            chk($sformatf("vec%0d gray", n), int'(gray4), tbl[n].expGray);
            chk($sformatf("vec%0d wrap", n), int'(wrap4), tbl[n].expWrap);
        end

        // Combinational next values around bin=7.
        iLoad = 1'b0; iRst = 1'b0; iInc = 1'b1; #1;
        chk("next7 inc bin", int'(binN4), 8);
        chk("next7 inc gray", int'(grayN4), 4'b1100);
        iInc = 1'b0; #1;
        chk("next7 hold bin", int'(binN4), 7);
        chk("next7 hold gray", int'(grayN4), 4'b0100);

        // Full-count sweep: 260 increments from reset on all widths.
        cycle(1, 0, 0, 8'h0);
        for (int k = 0; k < 3; k++) wrapCount[k] = 0;
        for (int n = 1; n <= 260; n++) begin
            cycle(0, 0, 1, 8'h0);
            if (n == 16) chk("sweep w4 wrap at 16", int'(wrap4), 1);
            if (n == 4)  chk("sweep w2 wrap at 4", int'(wrap2), 1);
            if (n == 256) begin
                chk("sweep w8 wrap at 256", int'(wrap8), 1);
                chk("sweep w8 gray at 256", int'(gray8), 0);
            end
            if (n == 255) chk("sweep w8 gray at 255", int'(gray8), 8'h80);
        end
        chk("sweep w2 wraps", wrapCount[0], 65);
        chk("sweep w4 wraps", wrapCount[1], 16);
        chk("sweep w8 wraps", wrapCount[2], 1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(31) == 0), ($urandom_range(7) == 0),
                  $urandom_range(1) == 1, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
